// File: rtl/sweep_position_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_position_ctrl: ping-pong servo sweep (0..7..0) with settle,        |
// | measure-request and timeout phases per position.                         |
// | Optional macro SWEEP_HOLD_EN adds a 'pausa' input that freezes timing.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sweep_position_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       medida_pronta,
`ifdef SWEEP_HOLD_EN
  input  logic       pausa,
`endif
  output logic [2:0] posicao,
  output logic       direcao,
  output logic       pedir_medida,
  output logic       fim_posicao,
  output logic       timeout,
  output logic [2:0] db_estado
);

  localparam int unsigned c_max_cycles = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                                         SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned c_timer_w    = $clog2(c_max_cycles) + 1;

  localparam logic [c_timer_w-1:0] c_settle_last  = c_timer_w'(SETTLE_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_timer_one    = c_timer_w'(1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_settle  = 3'd1;
  localparam logic [2:0] c_st_trigger = 3'd2;
  localparam logic [2:0] c_st_wait    = 3'd3;
  localparam logic [2:0] c_st_step    = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [c_timer_w-1:0] r_timer;
  logic [2:0]           r_pos;
  logic                 r_dir;
  logic                 r_flag;
  logic                 w_pausa;

`ifdef SWEEP_HOLD_EN
  assign w_pausa = pausa;
`else
  assign w_pausa = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; dropping ligar beats every other transition
  always_comb begin
    w_next = r_state;
    if (r_state != c_st_idle && !ligar) begin
      w_next = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (ligar) w_next = c_st_settle;
        end
        c_st_settle: begin
          if (!w_pausa && r_timer == c_settle_last) w_next = c_st_trigger;
        end
        c_st_trigger: begin
          w_next = c_st_wait;
        end
        c_st_wait: begin
          // A measurement ends the wait even while paused
          if (medida_pronta) begin
            w_next = c_st_step;
          end else if (!w_pausa && r_timer == c_timeout_last) begin
            w_next = c_st_step;
          end
        end
        c_st_step: begin
          w_next = c_st_settle;
        end
        default: begin
          w_next = c_st_idle;
        end
      endcase
    end
  end

  // Timer, timeout flag and sweep position
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_timer <= '0;
      r_flag  <= 1'b0;
      r_pos   <= 3'd0;
      r_dir   <= 1'b1;
    end else begin
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if ((r_state == c_st_settle || r_state == c_st_wait) && !w_pausa) begin
        r_timer <= r_timer + c_timer_one;
      end

      if (r_state == c_st_wait && w_next == c_st_step) begin
        r_flag <= !medida_pronta;
      end

      // Position only moves on a completed STEP, never on an abort to IDLE
      if (r_state == c_st_step && w_next == c_st_settle) begin
        if (r_dir) begin
          if (r_pos == 3'd7) begin
            r_pos <= 3'd6;
            r_dir <= 1'b0;
          end else begin
            r_pos <= r_pos + 3'd1;
          end
        end else begin
          if (r_pos == 3'd0) begin
            r_pos <= 3'd1;
            r_dir <= 1'b1;
          end else begin
            r_pos <= r_pos - 3'd1;
          end
        end
      end
    end
  end

  // Moore outputs
  always_comb begin
    posicao      = r_pos;
    direcao      = r_dir;
    db_estado    = r_state;
    pedir_medida = 1'b0;
    fim_posicao  = 1'b0;
    timeout      = 1'b0;
    case (r_state)
      c_st_trigger: pedir_medida = 1'b1;
      c_st_step: begin
        fim_posicao = 1'b1;
        timeout     = r_flag;
      end
      default: begin
        pedir_medida = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
